serial_adder: RTL and testbench

Bit-serial adder built around a single one-bit full-adder cell (inputs A, B, Cin; output Sum) plus a carry flip-flop.
- Loads two WIDTH-bit operands and a carry-in on `start`.
- Adds them LSB-first, one bit per clock, then presents the WIDTH-bit sum and carry-out with a one-cycle `done` pulse.
- Sits downstream of the lab's combinational adder cell and is the first sequential datapath of the lab series.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_fa_cell.sv | 23 ++
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder.
//   state_e        : control FSM states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default operand/sum width in bits
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32'd8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational one-bit full adder.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit      = a ^ b ^ cin
//   co        : carry-out    = majority(a, b, cin)
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s  = a ^ b ^ cin;
        co = (a & b) | (a & cin) | (b & cin);
    end

endmodule : fa_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: one full-adder cell plus a carry flip-flop processes the
// operands LSB-first, one bit per clock. The full result is published on the
// completion edge together with a one-cycle done pulse.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   start    : request, accepted only when not busy (IDLE or DONE)
//   a, b     : WIDTH-bit operands, captured on an accepted start
//   cin      : carry-in, captured on an accepted start
//   busy     : addition in progress
//   done     : one-cycle pulse, sum/cout were just updated
//   sum      : WIDTH-bit result of the last completed addition (held)
//   cout     : carry-out of the last completed addition (held)
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH, so it never wraps mid-operation.
    localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic               bit_s;
    logic               carry_s;

    // Single full-adder cell working on the current LSBs and stored carry.
    fa_cell u_fa_cell (
        .a   (opa_q[0]),
        .b   (opb_q[0]),
        .cin (carry_q),
        .s   (bit_s),
        .co  (carry_s)
    );

    // Next accumulator value: new sum bit enters at the MSB so that after
    // WIDTH shifts the first (LSB) result bit has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_d = bit_s;
        end else begin : g_acc_wn
            assign acc_d = {bit_s, acc_q[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM with datapath, counter and registered result/status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts a new start exactly like IDLE (back-to-back).
                IDLE, DONE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= carry_s;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Last bit: publish the result on this same edge.
                        sum_q   <= acc_d;
                        cout_q  <= carry_s;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clock = 1'b0;
    logic       reset_n;

    // WIDTH = 8 instance
    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    // WIDTH = 1 instance
    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [8:0] res;
        int         drv_cyc;
    } exp_t;
    exp_t q8[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] res;
    } vec_t;
    vec_t vecs[7];

    logic [8:0] last_res8;
    logic [1:0] exp1[8];

    always #5 clock = ~clock;

    serial_adder #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every done pops one expected result and checks latency.
    always @(negedge clock) begin
        if (reset_n && done8) begin
            chk("busy_at_done", 32'(busy8), 32'd0);
            chk("sb_pending", 32'(q8.size()), 32'd1);
            if (q8.size() > 0) begin
                exp_t e;
                e = q8.pop_front();
                chk("result8", 32'({cout8, sum8}), 32'(e.res));
                chk("latency8", 32'(cyc - e.drv_cyc), 32'd9);
            end
        end
    end

    // One WIDTH=8 transaction; optional ignored start pulse at loop index glitch_at.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] want, input int glitch_at);
        int busy_n;
        bit got;
        exp_t e;
        @(negedge clock);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        e.res = want; e.drv_cyc = cyc;
        q8.push_back(e);
        busy_n = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            if (k == glitch_at) begin
                a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
                if (k == 0) begin
                    a8 = ~a; b8 = ~b; cin8 = ~c;
                end
            end
            if (done8) begin
                got = 1'b1;
            end else begin
                if (busy8) busy_n++;
                chk("sum_hold", 32'({cout8, sum8}), 32'(last_res8));
            end
        end
        start8 = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_cycles", 32'(busy_n), 32'd8);
        last_res8 = want;
    endtask

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
        vecs[5] = '{8'h55, 8'hAA, 1'b1, 9'h100};
        vecs[6] = '{8'h3C, 8'hC3, 1'b0, 9'h0FF};
        exp1    = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        last_res8 = 9'h000;

        reset_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset8", 32'({busy8, done8, cout8, sum8}), 32'd0);
        chk("reset1", 32'({busy1, done1, cout1, sum1}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, -1);
        end

        // Start during SHIFT must be ignored
        run8(8'h12, 8'h34, 1'b0, 9'h046, 3);
        repeat (4) @(negedge clock);
        chk("no_extra_done", 32'({busy8, done8}), 32'd0);

        // Asynchronous reset mid-SHIFT
        @(negedge clock);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{9'h0FF, cyc});
        @(negedge clock);
        start8 = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({busy8, done8, cout8, sum8}), 32'd0);
        q8.delete();
        last_res8 = 9'h000;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("post_reset_idle", 32'({busy8, done8}), 32'd0);
        end
        run8(8'hAA, 8'h55, 1'b0, 9'h0FF, -1);

        // WIDTH=1 back-to-back, start held so each load happens in DONE
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            start1 = 1'b1;
            @(negedge clock);
            chk("w1_busy", 32'({busy1, done1}), 32'd2);
            @(negedge clock);
            chk("w1_done", 32'({busy1, done1}), 32'd1);
            chk("w1_result", 32'({cout1, sum1}), 32'(exp1[i]));
        end
        start1 = 1'b0;
        @(negedge clock);
        chk("w1_idle", 32'({busy1, done1}), 32'd0);

        // Random regression against the arithmetic model
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rc = 1'($urandom_range(1, 0));
            run8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, -1);
        end

        repeat (3) @(negedge clock);
        chk("sb_drained", 32'(q8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
